pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_target.sv | 28 ++
 rtl/pc_fetch.sv | 138 +++++++++++++
 tb/tb_pc_fetch.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: data width, next-PC source encodings and
// the fetch FSM state type.
package rv32i_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] PC_PLUS4   = 2'd0;
   localparam logic [1:0] PC_IMM     = 2'd1;
   localparam logic [1:0] PC_RS1_IMM = 2'd2;
   localparam logic [1:0] PC_RSVD    = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      WAIT = ST_WAIT,
      HOLD = ST_HOLD
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response channel plus the
// valid/ready hand-off towards decode.
interface pc_fetch_if;
   import rv32i_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_instr;

   modport master (
      output imem_req, imem_addr, if_valid, if_pc, if_instr,
      input  imem_gnt, imem_rvalid, imem_rdata, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_pc, if_instr,
      output imem_gnt, imem_rvalid, imem_rdata, if_ready
   );

endinterface

// File: rtl/pc_target.sv
// Redirect target generation for branches (ex_pc+imm) and JALR ((rs1+imm)&~1),
// with a flag for targets that are not 4-byte aligned.
module pc_target
   import rv32i_pkg::*;
(
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_val,
   output logic [XLEN-1:0] target,
   output logic            misalign
);

   logic [XLEN-1:0] br_sum;
   logic [XLEN-1:0] jr_sum;

   always_comb begin
      br_sum = ex_pc + imm;
      jr_sum = rs1_val + imm;
      if (pc_src == PC_RS1_IMM) begin
         target = {jr_sum[XLEN-1:1], 1'b0};
      end else begin
         target = br_sum;
      end
      misalign = target[1];
   end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding memory request, a single-entry
// output buffer towards decode, and branch/jump redirect with response kill.
module pc_fetch
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_val,
   pc_fetch_if.master      bus,
   output logic            misalign
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            kill_q, kill_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic            misalign_q, misalign_d;

   logic [XLEN-1:0] tgt;
   logic            tgt_misalign;
   logic            redirect;
   logic            take;
   logic            handshake;

   pc_target u_pc_target (
      .pc_src   (pc_src),
      .ex_pc    (ex_pc),
      .imm      (imm),
      .rs1_val  (rs1_val),
      .target   (tgt),
      .misalign (tgt_misalign)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      kill_d     = kill_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;

      redirect   = ex_valid && ((pc_src == PC_IMM) || (pc_src == PC_RS1_IMM));
      take       = redirect && !tgt_misalign;
      misalign_d = redirect && tgt_misalign;
      handshake  = if_valid_q && bus.if_ready;

      if (take) begin
         pc_d       = tgt;
         if_valid_d = 1'b0;
         case (state_q)
            REQ: begin
               state_d = bus.imem_gnt ? WAIT : REQ;
               kill_d  = bus.imem_gnt;
            end
            WAIT: begin
               state_d = bus.imem_rvalid ? REQ : WAIT;
               kill_d  = !bus.imem_rvalid;
            end
            default: begin
               state_d = REQ;
               kill_d  = 1'b0;
            end
         endcase
      end else begin
         if (handshake) begin
            if_valid_d = 1'b0;
         end
         case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (bus.imem_gnt) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = REQ;
                  end else if (!if_valid_q || handshake) begin
                     if_valid_d = 1'b1;
                     if_pc_d    = pc_q;
                     if_instr_d = bus.imem_rdata;
                     pc_d       = pc_q + 32'd4;
                     state_d    = REQ;
                  end else begin
                     // Buffer still occupied: drop the word and refetch the
                     // same pc once decode drains the buffer.
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (handshake) begin
                  state_d = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         kill_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         kill_q     <= kill_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.imem_req  = (state_q == REQ);
   assign bus.imem_addr = pc_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_instr  = if_instr_q;
   assign misalign      = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: latency-programmable memory model, expected
// fetch PCs queued by the stimulus and compared at every decode handshake.
module tb_pc_fetch;
   import rv32i_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [1:0]  pc_src;
   logic [31:0] ex_pc;
   logic [31:0] imm;
   logic [31:0] rs1_val;
   logic        misalign;

   logic        gnt_en;
   logic        if_ready;
   int          mem_lat;
   logic        pend;
   int          cnt;
   logic [31:0] paddr;
   int          gnt_cnt = 0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   pc_fetch_if bus ();

   pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ex_valid (ex_valid),
      .pc_src   (pc_src),
      .ex_pc    (ex_pc),
      .imm      (imm),
      .rs1_val  (rs1_val),
      .bus      (bus),
      .misalign (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Memory model: grant when enabled, answer mem_lat cycles after the grant.
   assign bus.imem_gnt    = bus.imem_req & gnt_en;
   assign bus.imem_rvalid = pend && (cnt == 0);
   assign bus.imem_rdata  = bus.imem_rvalid ? instr_of(paddr) : 32'h0;
   assign bus.if_ready    = if_ready;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend  <= 1'b0;
         cnt   <= 0;
         paddr <= 32'h0;
      end else if (bus.imem_req && bus.imem_gnt) begin
         pend    <= 1'b1;
         paddr   <= bus.imem_addr;
         cnt     <= mem_lat - 1;
         gnt_cnt <= gnt_cnt + 1;
      end else if (pend) begin
         if (cnt == 0) pend <= 1'b0;
         else          cnt  <= cnt - 1;
      end
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.if_valid && bus.if_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL extra_fetch: observed if_pc %h expected no fetch", bus.if_pc);
         end
         if (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check32("if_pc", bus.if_pc, e);
            check32("if_instr", bus.if_instr, instr_of(e));
         end
      end
   end

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check32("drain_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      if_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check1({tag, "_req"}, bus.imem_req, 1'b0);
      check32({tag, "_addr"}, bus.imem_addr, 32'h0000_0000);
      check1({tag, "_valid"}, bus.if_valid, 1'b0);
      check32({tag, "_pc"}, bus.if_pc, 32'h0);
      check32({tag, "_instr"}, bus.if_instr, 32'h0);
      check1({tag, "_misalign"}, misalign, 1'b0);
   endtask

   initial begin
      int start_gnt;
      int n;
      rst_n = 1'b1; gnt_en = 1'b1; if_ready = 1'b0; mem_lat = 1;
      ex_valid = 1'b0; pc_src = PC_PLUS4; ex_pc = '0; imm = '0; rs1_val = '0;
      #1 rst_n = 1'b0;
      #11;
      check_reset_outputs("rst");

      // Sequential fetch 0,4,8,12
      @(negedge clk);
      rst_n = 1'b1; if_ready = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h8); exp_q.push_back(32'hC);
      drain(60);

      // Decode stall: buffer holds pc 16, only one further request issued
      @(posedge clk);
      #1;
      start_gnt = gnt_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check1("stall_valid", bus.if_valid, 1'b1);
         check32("stall_pc", bus.if_pc, 32'h10);
         check32("stall_instr", bus.if_instr, instr_of(32'h10));
      end
      #1;
      check32("stall_grants", 32'(gnt_cnt - start_gnt), 32'd1);
      check1("stall_no_req", bus.imem_req, 1'b0);
      @(posedge clk);
      #1;
      exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
      if_ready = 1'b1;
      drain(60);

      // Branch redirect coincident with the pending response in WAIT
      ex_valid = 1'b1; pc_src = PC_IMM; ex_pc = 32'h100; imm = 32'h20;
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      exp_q.push_back(32'h120); exp_q.push_back(32'h124);
      if_ready = 1'b1;
      @(negedge clk);
      check1("redir_req", bus.imem_req, 1'b1);
      check32("redir_addr", bus.imem_addr, 32'h120);
      check1("redir_valid", bus.if_valid, 1'b0);
      drain(60);

      // Redirect in REQ with grant: slow response must be killed
      mem_lat = 3; if_ready = 1'b1;
      exp_q.push_back(32'h128); exp_q.push_back(32'h340); exp_q.push_back(32'h344);
      @(posedge clk);
      #1;
      ex_valid = 1'b1; pc_src = PC_IMM; ex_pc = 32'h300; imm = 32'h40;
      @(posedge clk);
      #1;
      ex_valid = 1'b0; mem_lat = 1;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (bus.imem_req) break;
         check1("kill_valid", bus.if_valid, 1'b0);
      end
      check32("kill_latency", 32'(n), 32'd4);
      check32("kill_addr", bus.imem_addr, 32'h340);
      drain(60);

      // JALR with misaligned target: pulse only, normal fetch continues
      ex_valid = 1'b1; pc_src = PC_RS1_IMM; rs1_val = 32'h201; imm = 32'h1;
      @(posedge clk);
      #1;
      pc_src = PC_RSVD; ex_pc = 32'h500; imm = 32'h0;
      @(negedge clk);
      check1("mis_pulse", misalign, 1'b1);
      check1("mis_valid", bus.if_valid, 1'b1);
      check32("mis_pc", bus.if_pc, 32'h348);
      check32("mis_addr", bus.imem_addr, 32'h34C);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      @(negedge clk);
      check1("mis_clear", misalign, 1'b0);
      check1("rsvd_wait", bus.imem_req, 1'b0);
      @(posedge clk);
      #1;
      ex_valid = 1'b1; pc_src = PC_RS1_IMM; rs1_val = 32'h203; imm = 32'h1;
      @(negedge clk);
      check1("hold_req", bus.imem_req, 1'b0);
      check32("hold_pc", bus.if_pc, 32'h348);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      exp_q.push_back(32'h204); exp_q.push_back(32'h208);
      if_ready = 1'b1;
      @(negedge clk);
      check1("jalr_req", bus.imem_req, 1'b1);
      check32("jalr_addr", bus.imem_addr, 32'h204);
      check1("jalr_valid", bus.if_valid, 1'b0);
      check1("jalr_mis", misalign, 1'b0);
      drain(60);

      // Address wrap: redirect to 0xFFFF_FFFC via negative immediate
      ex_valid = 1'b1; pc_src = PC_IMM; ex_pc = 32'h10; imm = 32'hFFFF_FFEC;
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
      if_ready = 1'b1;
      @(negedge clk);
      check32("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
      drain(60);

      // Reset asserted mid-WAIT, then grant withheld after release
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("wrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; gnt_en = 1'b0; if_ready = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check1("nogrant_req", bus.imem_req, 1'b1);
         check32("nogrant_addr", bus.imem_addr, 32'h0);
      end
      #1 gnt_en = 1'b1;
      drain(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
